// File: rtl/dm_load_unit.sv
// dm_load_unit: load-side companion to a synchronous-read data memory.
// Accepts one load at a time and reads one word, or two when the access
// crosses a word boundary. The bytes are merged little-endian and the
// result is sign- or zero-extended.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; latches word address, byte select, type
// RD0    | read strobe for the first word
// W0     | first word arrives; a spanning access issues the second read
// W1     | second word arrives; result registered with split=1
// DONE   | one-cycle done pulse with dout/split valid
module dm_load_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [2:0]  DMType,
    output logic        ready,
    output logic        mem_rd,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] dout,
    output logic        done,
    output logic        split
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_W0,
        S_W1,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_waddr;
    logic [1:0]  r_sel;
    logic [2:0]  r_type;
    logic [31:0] r_lo;
    logic [31:0] r_dout;
    logic        r_split;

    logic        w_is_half;
    logic        w_is_byte;
    logic        w_is_word;
    logic        w_signed;
    logic        w_span;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [63:0] w_pair;
    logic [31:0] w_field;
    logic [31:0] w_ext;

    // Decode the latched type; 101-111 fall through to word.
    always_comb begin
        w_is_half = (r_type == 3'b001) || (r_type == 3'b010);
        w_is_byte = (r_type == 3'b011) || (r_type == 3'b100);
        w_is_word = !w_is_half && !w_is_byte;
        w_signed  = (r_type == 3'b001) || (r_type == 3'b011);
        w_span    = (w_is_word && (r_sel != 2'd0)) || (w_is_half && (r_sel == 2'd3));
    end

    // Merge {hi,lo}, align to the byte select and extend. In W0 the
    // incoming word is lo and hi is zero; in W1 the incoming word is hi.
    always_comb begin
        w_hi    = (r_state == S_W1) ? mem_rdata : 32'd0;
        w_lo    = (r_state == S_W1) ? r_lo : mem_rdata;
        w_pair  = {w_hi, w_lo};
        w_field = w_pair[{r_sel, 3'b000} +: 32];
        w_ext   = w_field;
        if (w_is_half) begin
            w_ext = {{16{w_signed & w_field[15]}}, w_field[15:0]};
        end else if (w_is_byte) begin
            w_ext = {{24{w_signed & w_field[7]}}, w_field[7:0]};
        end
    end

    // Next-state and state-decoded outputs; no path from req/addr to the memory port.
    always_comb begin
        w_next   = r_state;
        ready    = 1'b0;
        done     = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = 30'd0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) w_next = S_RD0;
            end
            S_RD0: begin
                mem_rd   = 1'b1;
                mem_addr = r_waddr;
                w_next   = S_W0;
            end
            S_W0: begin
                if (w_span) begin
                    mem_rd   = 1'b1;
                    mem_addr = r_waddr + 30'd1;
                    w_next   = S_W1;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_W1: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, request latch, data capture and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_waddr <= 30'd0;
            r_sel   <= 2'd0;
            r_type  <= 3'd0;
            r_lo    <= 32'd0;
            r_dout  <= 32'd0;
            r_split <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req) begin
                r_waddr <= addr[31:2];
                r_sel   <= addr[1:0];
                r_type  <= DMType;
            end
            if (r_state == S_W0) begin
                r_lo <= mem_rdata;
                if (!w_span) begin
                    r_dout  <= w_ext;
                    r_split <= 1'b0;
                end
            end
            if (r_state == S_W1) begin
                r_dout  <= w_ext;
                r_split <= 1'b1;
            end
        end
    end

    assign dout  = r_dout;
    assign split = r_split;

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit with a small synchronous-read memory model.
module tb_dm_load_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  DMType;
    logic        ready;
    logic        mem_rd;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] dout;
    logic        done;
    logic        split;

    int n_tests = 0;
    int n_fail  = 0;

    dm_load_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .DMType    (DMType),
        .ready     (ready),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dout      (dout),
        .done      (done),
        .split     (split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        case (wa)
            30'h10:       mem_word = 32'h44332211;
            30'h11:       mem_word = 32'h887766F5;
            30'h3FFFFFFF: mem_word = 32'hA1B2C3D4;
            30'h0:        mem_word = 32'h5566778E;
            default:      mem_word = 32'hDEADBEEF;
        endcase
    endfunction

    // Synchronous-read memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One load, checked cycle by cycle. With busy=1, req stays high
    // through every busy cycle to show it is neither accepted nor queued.
    task automatic do_load(input string name, input logic [31:0] a, input logic [2:0] t,
                           input logic span, input logic [31:0] exp_dout, input logic busy);
        logic [29:0] wa;
        wa = a[31:2];
        @(negedge clk);
        req = 1'b1; addr = a; DMType = t;
        chk({name, " ready_idle"}, {31'd0, ready}, 32'd1);
        @(negedge clk);                      // T+1: RD0
        req = busy;
        addr = 32'h0000_0080; DMType = 3'b011;
        chk({name, " rd0_mem_rd"}, {31'd0, mem_rd}, 32'd1);
        chk({name, " rd0_mem_addr"}, {2'd0, mem_addr}, {2'd0, wa});
        chk({name, " rd0_ready"}, {31'd0, ready}, 32'd0);
        @(negedge clk);                      // T+2: W0
        chk({name, " w0_mem_rd"}, {31'd0, mem_rd}, {31'd0, span});
        if (span) chk({name, " w0_mem_addr"}, {2'd0, mem_addr}, {2'd0, wa + 30'd1});
        chk({name, " w0_done"}, {31'd0, done}, 32'd0);
        @(negedge clk);                      // T+3
        if (span) begin
            chk({name, " w1_done"}, {31'd0, done}, 32'd0);
            chk({name, " w1_mem_rd"}, {31'd0, mem_rd}, 32'd0);
            @(negedge clk);                  // T+4
        end
        chk({name, " done"}, {31'd0, done}, 32'd1);
        chk({name, " dout"}, dout, exp_dout);
        chk({name, " split"}, {31'd0, split}, {31'd0, span});
        chk({name, " done_ready"}, {31'd0, ready}, 32'd0);
        @(negedge clk);                      // back in IDLE
        req = 1'b0;
        chk({name, " post_done"}, {31'd0, done}, 32'd0);
        chk({name, " post_ready"}, {31'd0, ready}, 32'd1);
        chk({name, " post_dout_hold"}, dout, exp_dout);
        @(negedge clk);
        chk({name, " no_extra_rd"}, {31'd0, mem_rd}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = 32'd0; DMType = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset dout", dout, 32'd0);
        chk("reset split", {31'd0, split}, 32'd0);
        chk("reset mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("reset mem_addr", {2'd0, mem_addr}, 32'd0);
        rst = 1'b0;

        do_load("lw40",  32'h40, 3'b000, 1'b0, 32'h44332211, 1'b0);
        do_load("lw41",  32'h41, 3'b000, 1'b1, 32'hF5443322, 1'b0);
        do_load("lh43",  32'h43, 3'b001, 1'b1, 32'hFFFFF544, 1'b0);
        do_load("lhu43", 32'h43, 3'b010, 1'b1, 32'h0000F544, 1'b0);
        do_load("lh42",  32'h42, 3'b001, 1'b0, 32'h00004433, 1'b0);
        do_load("lb42",  32'h42, 3'b011, 1'b0, 32'h00000033, 1'b0);
        do_load("lb47",  32'h47, 3'b011, 1'b0, 32'hFFFFFF88, 1'b0);
        do_load("lbu47", 32'h47, 3'b100, 1'b0, 32'h00000088, 1'b0);
        do_load("lhu41", 32'h41, 3'b010, 1'b0, 32'h00003322, 1'b0);
        do_load("t7w43", 32'h43, 3'b111, 1'b1, 32'h7766F544, 1'b0);
        do_load("wrap",  32'hFFFFFFFD, 3'b000, 1'b1, 32'h8EA1B2C3, 1'b0);
        do_load("busy_lw41", 32'h41, 3'b000, 1'b1, 32'hF5443322, 1'b1);
        do_load("busy_lb40", 32'h40, 3'b011, 1'b0, 32'h00000011, 1'b1);

        // Reset during W0 of a spanning word load.
        @(negedge clk);
        req = 1'b1; addr = 32'h41; DMType = 3'b000;
        @(negedge clk);                      // RD0
        req = 1'b0;
        @(negedge clk);                      // W0
        chk("rstmid w0_mem_rd", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rstmid ready", {31'd0, ready}, 32'd1);
        chk("rstmid done", {31'd0, done}, 32'd0);
        chk("rstmid dout", dout, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid no_done", {31'd0, done}, 32'd0);
            chk("rstmid idle_ready", {31'd0, ready}, 32'd1);
        end
        do_load("lw40_after_rst", 32'h40, 3'b000, 1'b0, 32'h44332211, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
